// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT core group: sequencer FSM encoding, twiddle
// addressing modes and the default pipeline latencies also used by ct_butterfly.
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] MODE_BCAST  = 2'd0;
    localparam logic [1:0] MODE_STRIDE = 2'd1;
    localparam logic [1:0] MODE_LOCAL  = 2'd2;

    localparam int DEFAULT_READ_LATENCY = 1;
    localparam int DEFAULT_BF_LATENCY   = 6;

    // Early stages broadcast twiddles, middle stages stride, the last two stay core-local.
    function automatic logic [1:0] stage_mode(input logic [3:0] log_m,
                                              input int log_core_count,
                                              input int log_n);
        if (int'(log_m) < log_core_count) begin
            return MODE_BCAST;
        end else if (int'(log_m) < log_n - 2) begin
            return MODE_STRIDE;
        end
        return MODE_LOCAL;
    endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-depth shift register carrying {valid, address} from the BRAM read
// to the butterfly output so that writeback lands in place.
module ntt_wb_delay #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // NOTE: the taps are cleared, not left to power up, because a stale valid bit here would issue a spurious BRAM write.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps[k] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Steps one ntt_core group through all forward-NTT stages: sweeps the read
// addresses per stage, drains the pipeline, and issues aligned in-place writes.
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 5,
    parameter int ADDR_W         = 9,
    parameter int READ_LATENCY   = DEFAULT_READ_LATENCY,
    parameter int BF_LATENCY     = DEFAULT_BF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        log_m,
    output logic [9:0]        i,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] upper_read_address,
    output logic [ADDR_W-1:0] lower_read_address,
    output logic              write_enable,
    output logic [ADDR_W-1:0] upper_write_address,
    output logic [ADDR_W-1:0] lower_write_address
);

    localparam int                LAT        = READ_LATENCY + BF_LATENCY;
    localparam int                DRAIN_W    = $clog2(LAT + 1);
    localparam logic [ADDR_W-1:0] CNT_LAST   = '1;
    localparam logic [3:0]        LOG_M_LAST = 4'(LOG_N - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LAT - 1);

    seq_state_t         state, state_nx;
    logic [ADDR_W-1:0]  cnt, cnt_nx;
    logic [3:0]         log_m_nx;
    logic [DRAIN_W-1:0] drain_cnt, drain_nx;
    logic               push_valid;
    logic [ADDR_W-1:0]  tail_addr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            log_m     <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            log_m     <= log_m_nx;
            drain_cnt <= drain_nx;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a value unassigned and infers a latch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        log_m_nx   = log_m;
        drain_nx   = drain_cnt;
        push_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                    cnt_nx   = '0;
                    log_m_nx = '0;
                end
            end
            READ: begin
                push_valid = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nx = DRAIN;
                    drain_nx = '0;
                end else begin
                    cnt_nx = cnt + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    if (log_m == LOG_M_LAST) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = READ;
                        log_m_nx = log_m + 4'd1;
                        cnt_nx   = '0;
                    end
                end else begin
                    drain_nx = drain_cnt + DRAIN_W'(1);
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    ntt_wb_delay #(
        .DEPTH (LAT),
        .WIDTH (1 + ADDR_W)
    ) u_wb_delay (
        .clk   (clk),
        .clear (rst),
        .din   ({push_valid, cnt}),
        .dout  ({write_enable, tail_addr})
    );

    // cnt holds its last value outside READ, which gives the required address hold.
    assign upper_read_address  = cnt;
    assign lower_read_address  = cnt;
    assign i                   = 10'(cnt);
    assign upper_write_address = tail_addr;
    assign lower_write_address = tail_addr;
    assign busy                = (state == READ) || (state == DRAIN);
    assign done                = (state == DONE);
    assign mode                = stage_mode(log_m, LOG_CORE_COUNT, LOG_N);

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Randomised self-checking bench: a cycle-position model derived from the
// stage timing rules is compared against the sequencer on every cycle.
module tb_ntt_stage_sequencer;

    localparam int LOG_N          = 12;
    localparam int LOG_CORE_COUNT = 5;
    localparam int ADDR_W         = 9;
    localparam int LAT            = 7;
    localparam int NADDR          = 1 << ADDR_W;
    localparam int PER_STAGE      = NADDR + LAT;
    localparam int TOTAL          = LOG_N * PER_STAGE;
    localparam int DONE_T         = TOTAL + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        log_m;
    logic [9:0]        i;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] upper_read_address;
    logic [ADDR_W-1:0] lower_read_address;
    logic              write_enable;
    logic [ADDR_W-1:0] upper_write_address;
    logic [ADDR_W-1:0] lower_write_address;

    ntt_stage_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .log_m               (log_m),
        .i                   (i),
        .mode                (mode),
        .upper_read_address  (upper_read_address),
        .lower_read_address  (lower_read_address),
        .write_enable        (write_enable),
        .upper_write_address (upper_write_address),
        .lower_write_address (lower_write_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: m_t is the position since start acceptance (0 = idle); holds are idle values.
    int m_t          = 0;
    int m_hold_log_m = 0;
    int m_hold_rd    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_t          <= 0;
            m_hold_log_m <= 0;
            m_hold_rd    <= 0;
        end else if (m_t == 0) begin
            if (start) m_t <= 1;
        end else if (m_t == DONE_T) begin
            m_t          <= 0;
            m_hold_log_m <= LOG_N - 1;
            m_hold_rd    <= NADDR - 1;
        end else begin
            m_t <= m_t + 1;
        end
    end

    typedef struct {
        int busy;
        int done;
        int log_m;
        int mode;
        int rd;
        int we;
        int wa;
    } exp_t;

    function automatic exp_t expect_at(input int t, input int hold_log_m, input int hold_rd);
        exp_t e;
        int   s;
        int   o;
        e.busy  = 0;
        e.done  = 0;
        e.log_m = hold_log_m;
        e.rd    = hold_rd;
        e.we    = 0;
        e.wa    = 0;
        if (t >= 1 && t <= TOTAL) begin
            s       = (t - 1) / PER_STAGE;
            o       = (t - 1) % PER_STAGE;
            e.busy  = 1;
            e.log_m = s;
            e.rd    = (o < NADDR) ? o : NADDR - 1;
            if (o >= LAT) begin
                e.we = 1;
                e.wa = o - LAT;
            end
        end else if (t == DONE_T) begin
            e.done  = 1;
            e.log_m = LOG_N - 1;
            e.rd    = NADDR - 1;
        end
        e.mode = (e.log_m < LOG_CORE_COUNT) ? 0 : (e.log_m < LOG_N - 2) ? 1 : 2;
        return e;
    endfunction

    int mode_lit [LOG_N] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2};
    int acc_cyc    = 0;
    int first_we   = -1;
    int done_rel   = -1;
    int s0_writes  = 0;
    int all_writes = 0;

    always @(negedge clk) begin : compare
        exp_t e;
        if (chk_en) begin
            e = expect_at(m_t, m_hold_log_m, m_hold_rd);
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("log_m", log_m, e.log_m);
            check("mode", mode, e.mode);
            check("upper_read_address", upper_read_address, e.rd);
            check("lower_read_address", lower_read_address, e.rd);
            check("i", i, e.rd);
            check("write_enable", write_enable, e.we);
            if (e.we != 0) begin
                check("upper_write_address", upper_write_address, e.wa);
                check("lower_write_address", lower_write_address, e.wa);
            end
            if (m_t >= 1 && m_t <= TOTAL && (m_t - 1) % PER_STAGE == 0)
                check("stage_mode_literal", mode, mode_lit[(m_t - 1) / PER_STAGE]);

            if (m_t == 1) begin
                acc_cyc    <= cyc - 1;
                first_we   <= -1;
                done_rel   <= -1;
                s0_writes  <= 0;
                all_writes <= 0;
            end else begin
                if (write_enable === 1'b1) begin
                    if (first_we < 0) first_we <= cyc - acc_cyc;
                    all_writes <= all_writes + 1;
                    if (log_m == 4'd0) s0_writes <= s0_writes + 1;
                end
                if (done === 1'b1) done_rel <= cyc - acc_cyc;
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int target);
        wait_cyc(target);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_run(input string tag);
        check({tag, "_first_write_cycle"}, first_we, 8);
        check({tag, "_done_cycle"}, done_rel, 6229);
        check({tag, "_stage0_writes"}, s0_writes, 512);
        check({tag, "_total_writes"}, all_writes, 6144);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a;
        int b;
        int c;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle with start never asserted.
        repeat (100) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_write_enable", write_enable, 0);
        check("idle_read_address", upper_read_address, 0);
        check("idle_log_m", log_m, 0);

        // Run A with ignored start pulses, then start held through the DONE cycle.
        start = 1'b1;
        a     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulse_start(a + 50);
        pulse_start(a + int'($urandom_range(100, 2900)));
        pulse_start(a + 3000);
        pulse_start(a + int'($urandom_range(3100, 6100)));
        wait_cyc(a + 6229);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_run("A");
        b = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Run B is reset in stage 3 at read index 100.
        wait_cyc(b + 1658);
        check("rst_point_read_address", upper_read_address, 100);
        check("rst_point_log_m", log_m, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("after_rst_write_enable", write_enable, 0);
        check("after_rst_write_address", upper_write_address, 0);
        check("after_rst_log_m", log_m, 0);
        check("after_rst_busy", busy, 0);
        check("after_rst_read_address", upper_read_address, 0);
        check("B_stage0_writes", s0_writes, 512);
        check("B_no_done", done_rel, -1);
        repeat ($urandom_range(5, 40)) @(posedge clk);
        #1;

        // Run C completes after the aborted run.
        start = 1'b1;
        c     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(c + 6230);
        check_run("C");

        repeat (10) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
